jit_couple_sched: RTL and testbench

- Transaction sequencer for the accelerator coupling block.
- Accepts one command per transaction over a stream, then drives the 6-bit coupling CONF word that selects the A/B operand sources and the C result destination.
- Counts handshakes on the A, B and C accelerator-side streams and closes each path exactly after its programmed beat count, so no stray beat crosses a reconfiguration.
- Then returns one status word and goes back to idle.

---
 rtl/jit_couple_sched.sv | 135 +++++++++++++
 tb/tb_jit_couple_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jit_couple_sched.sv
// Transaction sequencer for the accelerator coupling block: takes one command, routes
// A/B/C through CONF for exactly the programmed beat counts, then returns a status word.
module jit_couple_sched #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        ACLK,
  input  logic        ARESET,
  output logic        sCmd_tready,
  input  logic        sCmd_tvalid,
  input  logic [31:0] sCmd_tdata,
  input  logic        mSts_tready,
  output logic        mSts_tvalid,
  output logic [31:0] mSts_tdata,
  output logic [5:0]  CONF,
  input  logic        mAccOutA_tvalid,
  input  logic        mAccOutA_tready,
  input  logic        mAccOutB_tvalid,
  input  logic        mAccOutB_tready,
  input  logic        sAccInC_tvalid,
  input  logic        sAccInC_tready,
  input  logic        ABORT,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  state_t      state_reg;
  logic [11:0] len_in_reg;
  logic [11:0] len_out_reg;
  logic [11:0] cnt_reg [3];
  logic [29:0] cycles_reg;

  // Path index 2 = A, 1 = B, 0 = C, so path gi owns CONF[2*gi +: 2].
  logic [2:0]  path_vld;
  logic [2:0]  path_rdy;
  logic [2:0]  path_done;
  logic [2:0]  path_beat;
  logic [2:0]  path_last;
  logic [11:0] path_len [3];

  assign path_vld = {mAccOutA_tvalid, mAccOutB_tvalid, sAccInC_tvalid};
  assign path_rdy = {mAccOutA_tready, mAccOutB_tready, sAccInC_tready};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_path
      assign path_len[gi]  = (gi == 0) ? len_out_reg : len_in_reg;
      assign path_done[gi] = (CONF[2*gi +: 2] == 2'b00) || (cnt_reg[gi] == path_len[gi]);
      assign path_beat[gi] = path_vld[gi] && path_rdy[gi] && !path_done[gi];
      assign path_last[gi] = path_beat[gi] && ((cnt_reg[gi] + 12'd1) == path_len[gi]);
    end
  endgenerate

  logic        all_done;
  logic        all_done_next;
  logic [29:0] cycles_inc;
  logic        timeout_hit;
  logic        unused_rsvd;

  assign all_done      = &path_done;
  // Paths finishing on this very edge count as completion, so an abort here loses.
  assign all_done_next = &(path_done | path_last);
  assign cycles_inc    = (cycles_reg == '1) ? cycles_reg : cycles_reg + 30'd1;
  assign timeout_hit   = (TIMEOUT != 0) && ({2'b00, cycles_inc} >= TIMEOUT);
  assign unused_rsvd   = ^sCmd_tdata[7:6];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg   <= IDLE;
      sCmd_tready <= 1'b0;
      mSts_tvalid <= 1'b0;
      mSts_tdata  <= '0;
      CONF        <= '0;
      BUSY        <= 1'b0;
      len_in_reg  <= '0;
      len_out_reg <= '0;
      cycles_reg  <= '0;
      for (int i = 0; i < 3; i++) cnt_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          sCmd_tready <= 1'b1;
          mSts_tvalid <= 1'b0;
          BUSY        <= 1'b0;
          if (sCmd_tready && sCmd_tvalid) begin
            len_in_reg  <= sCmd_tdata[19:8];
            len_out_reg <= sCmd_tdata[31:20];
            CONF[5:4]   <= (sCmd_tdata[19:8]  == 12'd0) ? 2'b00 : sCmd_tdata[5:4];
            CONF[3:2]   <= (sCmd_tdata[19:8]  == 12'd0) ? 2'b00 : sCmd_tdata[3:2];
            CONF[1:0]   <= (sCmd_tdata[31:20] == 12'd0) ? 2'b00 : sCmd_tdata[1:0];
            cycles_reg  <= '0;
            for (int i = 0; i < 3; i++) cnt_reg[i] <= '0;
            sCmd_tready <= 1'b0;
            BUSY        <= 1'b1;
            state_reg   <= RUN;
          end
        end
        RUN: begin
          cycles_reg <= cycles_inc;
          if (all_done) begin
            CONF        <= '0;
            mSts_tvalid <= 1'b1;
            mSts_tdata  <= {2'b00, cycles_inc};
            state_reg   <= REPORT;
          end else if ((ABORT || timeout_hit) && !all_done_next) begin
            CONF        <= '0;
            mSts_tvalid <= 1'b1;
            mSts_tdata  <= {1'b1, timeout_hit, cycles_inc};
            state_reg   <= REPORT;
          end else begin
            for (int i = 0; i < 3; i++) begin
              if (path_beat[i]) cnt_reg[i] <= cnt_reg[i] + 12'd1;
              if (path_last[i]) CONF[2*i +: 2] <= 2'b00;
            end
          end
        end
        REPORT: begin
          CONF <= '0;
          if (mSts_tready) begin
            mSts_tvalid <= 1'b0;
            sCmd_tready <= 1'b1;
            BUSY        <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: begin
          state_reg   <= IDLE;
          CONF        <= '0;
          mSts_tvalid <= 1'b0;
          BUSY        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jit_couple_sched.sv
// Randomized and directed bench for jit_couple_sched; expectations come from a per-transaction
// model that finds each path's closing edge from the stimulus tables.
module tb_jit_couple_sched;

  localparam int TO = 20;
  localparam int MAXE = 64;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        sCmd_tready;
  logic        sCmd_tvalid = 1'b0;
  logic [31:0] sCmd_tdata = '0;
  logic        mSts_tready = 1'b0;
  logic        mSts_tvalid;
  logic [31:0] mSts_tdata;
  logic [5:0]  CONF;
  logic        mAccOutA_tvalid = 1'b0, mAccOutA_tready = 1'b0;
  logic        mAccOutB_tvalid = 1'b0, mAccOutB_tready = 1'b0;
  logic        sAccInC_tvalid = 1'b0, sAccInC_tready = 1'b0;
  logic        ABORT = 1'b0;
  logic        BUSY;

  int errors = 0;
  int checks = 0;

  // Per-edge stimulus tables; path 0 = A, 1 = B, 2 = C; edge 1 is the first RUN edge.
  bit vld [3][MAXE];
  bit rdy [3][MAXE];

  jit_couple_sched #(.TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .sCmd_tready(sCmd_tready), .sCmd_tvalid(sCmd_tvalid), .sCmd_tdata(sCmd_tdata),
    .mSts_tready(mSts_tready), .mSts_tvalid(mSts_tvalid), .mSts_tdata(mSts_tdata),
    .CONF(CONF),
    .mAccOutA_tvalid(mAccOutA_tvalid), .mAccOutA_tready(mAccOutA_tready),
    .mAccOutB_tvalid(mAccOutB_tvalid), .mAccOutB_tready(mAccOutB_tready),
    .sAccInC_tvalid(sAccInC_tvalid), .sAccInC_tready(sAccInC_tready),
    .ABORT(ABORT), .BUSY(BUSY)
  );

  always #5 ACLK = ~ACLK;

  task automatic clear_stim();
    for (int p = 0; p < 3; p++)
      for (int e = 0; e < MAXE; e++) begin
        vld[p][e] = 1'b0;
        rdy[p][e] = 1'b0;
      end
  endtask

  task automatic idle_inputs();
    mAccOutA_tvalid = 0; mAccOutA_tready = 0;
    mAccOutB_tvalid = 0; mAccOutB_tready = 0;
    sAccInC_tvalid = 0;  sAccInC_tready = 0;
    ABORT = 0;
  endtask

  task automatic drive_edge(input int e);
    mAccOutA_tvalid = vld[0][e]; mAccOutA_tready = rdy[0][e];
    mAccOutB_tvalid = vld[1][e]; mAccOutB_tready = rdy[1][e];
    sAccInC_tvalid  = vld[2][e]; sAccInC_tready  = rdy[2][e];
  endtask

  // Beats in a range of edges on one path, ready either always high or toggling.
  task automatic beats(input int p, input int first, input int last, input bit toggle);
    for (int e = first; e <= last; e++) begin
      vld[p][e] = 1'b1;
      rdy[p][e] = toggle ? bit'(e % 2) : 1'b1;
    end
  endtask

  function automatic logic [5:0] conf_at(input logic [5:0] c, input int la, input int lb,
                                         input int lc, input int e);
    logic [5:0] r;
    r = c;
    if (la == 0 || e >= la) r[5:4] = 2'b00;
    if (lb == 0 || e >= lb) r[3:2] = 2'b00;
    if (lc == 0 || e >= lc) r[1:0] = 2'b00;
    return r;
  endfunction

  task automatic run_txn(input string name, input logic [5:0] conf, input logic [11:0] lin,
                         input logic [11:0] lout, input int abort_edge, input int sts_delay);
    int L [3];
    int k, e_end, w, cnt, lens, field;
    logic [31:0] exp_sts;
    // Model: a path closes on the edge of its LEN-th handshake; completion is seen one edge later.
    k = 0;
    for (int p = 0; p < 3; p++) begin
      lens  = (p == 2) ? int'(lout) : int'(lin);
      field = int'((conf >> (4 - 2 * p)) & 6'd3);
      if (field == 0 || lens == 0) L[p] = 0;
      else begin
        L[p] = 999;
        cnt = 0;
        for (int e = 1; e < MAXE; e++)
          if (vld[p][e] && rdy[p][e] && L[p] == 999) begin
            cnt++;
            if (cnt == lens) L[p] = e;
          end
      end
      if (L[p] > k) k = L[p];
    end
    e_end = k + 1;
    if (abort_edge >= 1 && abort_edge < k && abort_edge < e_end) e_end = abort_edge;
    if (TO < k && TO < e_end) e_end = TO;
    if (e_end == k + 1) exp_sts = {2'b00, 30'(e_end)};
    else exp_sts = {1'b1, (e_end == TO), 30'(e_end)};

    w = 0;
    while (sCmd_tready !== 1'b1 && w < 10) begin
      @(posedge ACLK); #1;
      w++;
    end
    checks++;
    if (sCmd_tready !== 1'b1)
      $display("FAIL %s cmd_ready: got %b want 1", name, sCmd_tready);

    sCmd_tdata  = {lout, lin, 2'($urandom), conf};
    sCmd_tvalid = 1'b1;
    @(posedge ACLK); #1;
    sCmd_tvalid = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || sCmd_tready !== 1'b0 || CONF !== conf_at(conf, L[0], L[1], L[2], 0)) begin
      errors++;
      $display("FAIL %s accept: busy=%b rdy=%b conf=%b want busy=1 rdy=0 conf=%b", name, BUSY,
               sCmd_tready, CONF, conf_at(conf, L[0], L[1], L[2], 0));
    end

    for (int e = 1; e <= e_end; e++) begin
      drive_edge(e);
      ABORT = (e == abort_edge);
      @(posedge ACLK); #1;
      checks++;
      if (e < e_end) begin
        if (CONF !== conf_at(conf, L[0], L[1], L[2], e) || mSts_tvalid !== 1'b0 ||
            BUSY !== 1'b1 || sCmd_tready !== 1'b0) begin
          errors++;
          $display("FAIL %s run_e%0d: conf=%b vld=%b busy=%b rdy=%b want conf=%b vld=0 busy=1 rdy=0",
                   name, e, CONF, mSts_tvalid, BUSY, sCmd_tready, conf_at(conf, L[0], L[1], L[2], e));
        end
      end else begin
        if (mSts_tvalid !== 1'b1 || mSts_tdata !== exp_sts || CONF !== 6'd0) begin
          errors++;
          $display("FAIL %s status: vld=%b data=%h conf=%b want vld=1 data=%h conf=0", name,
                   mSts_tvalid, mSts_tdata, CONF, exp_sts);
        end
      end
    end
    idle_inputs();

    for (int d = 0; d < sts_delay; d++) begin
      @(posedge ACLK); #1;
      checks++;
      if (mSts_tvalid !== 1'b1 || mSts_tdata !== exp_sts || sCmd_tready !== 1'b0 ||
          BUSY !== 1'b1 || CONF !== 6'd0) begin
        errors++;
        $display("FAIL %s hold_%0d: vld=%b data=%h rdy=%b busy=%b conf=%b want vld=1 data=%h rdy=0 busy=1 conf=0",
                 name, d, mSts_tvalid, mSts_tdata, sCmd_tready, BUSY, CONF, exp_sts);
      end
    end

    mSts_tready = 1'b1;
    @(posedge ACLK); #1;
    mSts_tready = 1'b0;
    checks++;
    if (mSts_tvalid !== 1'b0 || BUSY !== 1'b0 || sCmd_tready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: vld=%b busy=%b rdy=%b want vld=0 busy=0 rdy=1", name,
               mSts_tvalid, BUSY, sCmd_tready);
    end
    $display("txn %s conf=%b lin=%0d lout=%0d abort_e=%0d status=%h expected=%h", name, conf,
             lin, lout, abort_edge, mSts_tdata, exp_sts);
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    checks++;
    if (sCmd_tready !== 1'b0 || mSts_tvalid !== 1'b0 || mSts_tdata !== 32'd0 ||
        CONF !== 6'd0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b data=%h conf=%b busy=%b want all 0", sCmd_tready,
               mSts_tvalid, mSts_tdata, CONF, BUSY);
    end
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    checks++;
    if (sCmd_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", sCmd_tready);
    end
    $display("txn reset done");
  endtask

  task automatic test_basic();
    clear_stim();
    beats(0, 1, 6, 0);
    beats(1, 1, 6, 0);
    beats(2, 1, 3, 0);
    run_txn("basic", 6'b01_01_01, 12'd4, 12'd2, 0, 0);
  endtask

  task automatic test_staggered();
    clear_stim();
    beats(0, 1, 3, 0);
    beats(1, 1, 3, 0);
    beats(2, 6, 10, 0);
    run_txn("staggered", 6'b01_01_01, 12'd3, 12'd5, 0, 1);
  endtask

  task automatic test_backpressure();
    clear_stim();
    beats(0, 1, 12, 1);
    beats(1, 1, 12, 0);
    beats(2, 2, 4, 0);
    run_txn("backpressure", 6'b10_01_11, 12'd4, 12'd1, 0, 10);
  endtask

  task automatic test_abort_timeout();
    clear_stim();
    beats(0, 1, 10, 0);
    beats(1, 1, 10, 0);
    beats(2, 1, 10, 0);
    run_txn("abort_mid", 6'b01_01_01, 12'd8, 12'd8, 2, 0);
    clear_stim();
    run_txn("timeout", 6'b11_10_01, 12'd4, 12'd4, 0, 2);
    clear_stim();
    beats(0, 1, 3, 0);
    beats(1, 1, 3, 0);
    beats(2, 1, 3, 0);
    run_txn("abort_final", 6'b01_01_01, 12'd3, 12'd3, 3, 0);
  endtask

  task automatic test_zero_masked();
    clear_stim();
    beats(0, 1, 5, 0);
    beats(2, 1, 5, 0);
    run_txn("zero_len", 6'b11_11_11, 12'd0, 12'd0, 0, 0);
    clear_stim();
    beats(0, 1, 8, 0);
    beats(1, 2, 8, 0);
    beats(2, 3, 8, 0);
    run_txn("masked_a", 6'b00_10_10, 12'd4, 12'd3, 0, 0);
  endtask

  task automatic test_reset_mid_run();
    clear_stim();
    sCmd_tdata  = {12'd8, 12'd8, 2'b00, 6'b01_01_01};
    sCmd_tvalid = 1'b1;
    @(posedge ACLK); #1;
    sCmd_tvalid = 1'b0;
    for (int e = 0; e < 2; e++) begin
      mAccOutA_tvalid = 1; mAccOutA_tready = 1;
      mAccOutB_tvalid = 1; mAccOutB_tready = 1;
      @(posedge ACLK); #1;
    end
    idle_inputs();
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    checks++;
    if (CONF !== 6'd0 || BUSY !== 1'b0 || mSts_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: conf=%b busy=%b vld=%b want 0 0 0", CONF, BUSY, mSts_tvalid);
    end
    @(posedge ACLK); #1;
    checks++;
    if (sCmd_tready !== 1'b1 || mSts_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready: rdy=%b vld=%b want rdy=1 vld=0", sCmd_tready, mSts_tvalid);
    end
    $display("txn reset_mid_run done");
    clear_stim();
    beats(0, 1, 5, 0);
    beats(1, 1, 5, 0);
    beats(2, 1, 5, 0);
    run_txn("after_reset", 6'b01_01_01, 12'd3, 12'd2, 0, 0);
  endtask

  task automatic test_random();
    logic [5:0]  conf;
    logic [11:0] lin, lout;
    int ab;
    for (int t = 0; t < 40; t++) begin
      clear_stim();
      for (int p = 0; p < 3; p++)
        for (int e = 1; e < MAXE; e++) begin
          vld[p][e] = ($urandom_range(0, 3) != 0);
          rdy[p][e] = ($urandom_range(0, 3) != 0);
        end
      conf = 6'($urandom);
      lin  = 12'($urandom_range(0, 6));
      lout = 12'($urandom_range(0, 6));
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
      run_txn($sformatf("rand%0d", t), conf, lin, lout, ab, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_staggered();
    test_backpressure();
    test_abort_timeout();
    test_zero_masked();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
